std_fifo_prog: RTL and testbench

Parametrised synchronous FIFO: the next generation of the team's standard FIFO. Adds runtime-programmable almost-empty/almost-full thresholds, a correctly sized occupancy count, and sticky overflow/underflow error flags. A compile-time option selects first-word-fall-through output. It is the default buffering element between streaming pipeline stages in a single clock domain.

---
 rtl/std_fifo_prog.sv | 148 ++++++++++++++
 tb/tb_std_fifo_prog.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/std_fifo_prog.sv
// ============================================================================
// std_fifo_prog
// ----------------------------------------------------------------------------
// Parametrised single-clock FIFO with runtime-programmable almost-empty /
// almost-full thresholds, a full-range occupancy count and sticky
// overflow / underflow error flags.
//
// Compile-time option:
//   STD_FIFO_PROG_FWFT_EN  defined   -> first-word-fall-through: q shows the
//                                       head entry combinationally whenever
//                                       the FIFO is not empty.
//                          undefined -> registered read: data popped at edge N
//                                       appears on q after edge N and holds.
//
// Parameters:
//   WIDTH  data word width in bits (>= 1)
//   DEPTH  number of entries, power of two, >= 2
//   CW     derived width of count and thresholds (holds 0..DEPTH)
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   push, d       write request and data
//   pop, q        read request and data
//   full, empty   occupancy decodes of count
//   count         current occupancy (0..DEPTH)
//   ae_thresh     almost_empty asserted while count <= ae_thresh
//   af_thresh     almost_full asserted while count >= af_thresh
//   almost_empty  see ae_thresh
//   almost_full   see af_thresh
//   clr_err       clears overflow / underflow (a same-edge set event wins)
//   overflow      sticky: a push was rejected because the FIFO was full
//   underflow     sticky: a pop was rejected because the FIFO was empty
// ============================================================================
module std_fifo_prog #(
    parameter int   WIDTH = 8,
    parameter int   DEPTH = 16,
    localparam int  CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             almost_empty,
    output logic             almost_full,
    input  logic [CW-1:0]    ae_thresh,
    input  logic [CW-1:0]    af_thresh,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Status decodes come straight from the count register and the live
    // threshold inputs, so a threshold change moves the flags immediately.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_empty = (count <= ae_thresh);
    assign almost_full  = (count >= af_thresh);

    // A pop is only legal on stored data; a simultaneous push never rescues
    // a pop on an empty FIFO. A push at full is legal when a pop frees a slot
    // on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Storage is not reset; the reset edge suppresses the write so a push
    // issued during reset leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= d;
        end
    end

    // Pointers wrap naturally at DEPTH because they are exactly log2(DEPTH)
    // bits wide. count only changes when exactly one side is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky error flags: a set event on the same edge as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (pop && !pop_ok) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef STD_FIFO_PROG_FWFT_EN
    // Head entry is always on the output; its value while empty is
    // meaningless and consumers must qualify it with empty.
    assign q = mem[rd_ptr];
`else
    // Registered read. At full with push+pop the write lands on the slot being
    // read; the non-blocking read returns the old head, which is correct.
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (pop_ok) begin
            q_reg <= mem[rd_ptr];
        end
    end

    assign q = q_reg;
`endif

endmodule

// File: tb/tb_std_fifo_prog.sv
// ============================================================================
// tb_std_fifo_prog
// ----------------------------------------------------------------------------
// Directed and random stimulus for std_fifo_prog against a queue-based
// behavioural model of the FIFO.
// ============================================================================
module tb_std_fifo_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    ae_thresh;
    logic [CW-1:0]    af_thresh;
    logic             clr_err;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q;
    bit               exp_ovf;
    bit               exp_unf;

    std_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .d            (d),
        .q            (q),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .ae_thresh    (ae_thresh),
        .af_thresh    (af_thresh),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Compare every output against what the model says the FIFO must show.
    task automatic checkAll();
        int n;
        n = model_q.size();
        checkOutput("count", 32'(count), 32'(n));
        checkOutput("empty", 32'(empty), 32'(n == 0));
        checkOutput("full", 32'(full), 32'(n == DEPTH));
        checkOutput("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_thresh)));
        checkOutput("almost_full", 32'(almost_full), 32'(n >= int'(af_thresh)));
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("underflow", 32'(underflow), 32'(exp_unf));
`ifdef STD_FIFO_PROG_FWFT_EN
        if (n > 0) checkOutput("q_fwft", 32'(q), 32'(model_q[0]));
`else
        checkOutput("q", 32'(q), 32'(exp_q));
`endif
    endtask

    // One clock edge with the given inputs; the model advances on the same
    // edge from its own pre-edge state, then all outputs are checked.
    task automatic applyStimulus(input bit r, input bit ps, input bit pp,
                                 input logic [WIDTH-1:0] data, input bit clr);
        bit pop_ok;
        bit push_ok;
        rst = r; push = ps; pop = pp; d = data; clr_err = clr;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            exp_ovf = 0;
            exp_unf = 0;
            exp_q   = '0;
        end else begin
            pop_ok  = pp && (model_q.size() > 0);
            push_ok = ps && ((model_q.size() < DEPTH) || pop_ok);
            if (pop_ok) exp_q = model_q.pop_front();
            if (push_ok) model_q.push_back(data);
            if (ps && !push_ok) exp_ovf = 1;
            else if (clr) exp_ovf = 0;
            if (pp && !pop_ok) exp_unf = 1;
            else if (clr) exp_unf = 0;
        end
        #1;
        checkAll();
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; d = '0; clr_err = 1'b0;
        ae_thresh = CW'(2);
        af_thresh = CW'(14);
        exp_q = '0; exp_ovf = 0; exp_unf = 0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'h00, 0);
        checkOutput("reset_q", 32'(q), 32'h0);
        checkOutput("reset_count", 32'(count), 32'd0);

        // Fill to full, then a rejected push
        for (int i = 1; i <= 16; i++) applyStimulus(0, 1, 0, 8'(i), 0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_count", 32'(count), 32'd16);
        applyStimulus(0, 1, 0, 8'd99, 0);
        checkOutput("ovf_count", 32'(count), 32'd16);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 0, 1, 8'h00, 0);
`ifndef STD_FIFO_PROG_FWFT_EN
            checkOutput("drain_q", 32'(q), 32'(i));
`endif
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("ovf_clear", 32'(overflow), 32'd0);

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 8'(i + 32), 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 8'h00, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'(8'hA0 + i), 0);
        checkOutput("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 8'h00, 0);

        // Push+pop at full
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'(i + 64), 0);
        applyStimulus(0, 1, 1, 8'h55, 0);
        checkOutput("full_pp_count", 32'(count), 32'd16);
        checkOutput("full_pp_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, 8'h00, 0);
`ifndef STD_FIFO_PROG_FWFT_EN
        checkOutput("full_pp_last", 32'(q), 32'h55);
`endif

        // Push+pop at empty
        applyStimulus(0, 1, 1, 8'h33, 0);
        checkOutput("empty_pp_count", 32'(count), 32'd1);
        checkOutput("empty_pp_unf", 32'(underflow), 32'd1);
        applyStimulus(0, 0, 1, 8'h00, 1);
`ifndef STD_FIFO_PROG_FWFT_EN
        checkOutput("empty_pp_q", 32'(q), 32'h33);
`endif

        // Threshold boundaries, one push per cycle
        ae_thresh = CW'(2);
        af_thresh = CW'(14);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 1, 0, 8'(i + 128), 0);
            if (i == 2) checkOutput("ae_at3", 32'(almost_empty), 32'd0);
            if (i == 12) checkOutput("af_at13", 32'(almost_full), 32'd0);
        end
        checkOutput("af_at14", 32'(almost_full), 32'd1);
        af_thresh = CW'(16);
        #1;
        checkOutput("af_moved", 32'(almost_full), 32'd0);
        af_thresh = CW'(0);
        #1;
        checkOutput("af_zero", 32'(almost_full), 32'd1);
        af_thresh = CW'(14);
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("ae_at0", 32'(almost_empty), 32'd1);

        // Reset mid-operation with count 7 and overflow set
        for (int i = 0; i < 17; i++) applyStimulus(0, 1, 0, 8'(i + 200), 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("pre_rst_count", 32'(count), 32'd7);
        checkOutput("pre_rst_ovf", 32'(overflow), 32'd1);
        applyStimulus(1, 1, 0, 8'hEE, 0);
        checkOutput("rst_mid_count", 32'(count), 32'd0);
        checkOutput("rst_mid_empty", 32'(empty), 32'd1);
        checkOutput("rst_mid_ovf", 32'(overflow), 32'd0);
        applyStimulus(0, 0, 1, 8'h00, 0);
        checkOutput("rst_mid_unf", 32'(underflow), 32'd1);

        // Random traffic with drifting push/pop bias and thresholds
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 200) % 3;
            if ($urandom_range(0, 63) == 0) ae_thresh = CW'($urandom_range(0, DEPTH + 1));
            if ($urandom_range(0, 63) == 0) af_thresh = CW'($urandom_range(0, DEPTH + 1));
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2)),
                          $urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2)),
                          8'($urandom),
                          $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
